// File: rtl/vga_gfx_pkg.sv
// Shared types and constants for the bouncing-box pixel source.
package vga_gfx_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      UPD_X = 2'd1,
      UPD_Y = 2'd2,
      DONE  = 2'd3
   } upd_state_t;

   // Width of position arithmetic; one spare bit so a step below zero shows as negative
   localparam int POS_W = 12;

   // 640x480 timing as seen through the driver's raster counters
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int H_OFFSET_DEF = 144;
   localparam int V_OFFSET_DEF = 35;
   localparam int BOX_SIZE_DEF = 32;
   localparam int SPEED_DEF    = 2;

   localparam rgb_t PALETTE [4] = '{
      '{8'hFF, 8'h00, 8'h00},   // red
      '{8'h00, 8'hFF, 8'h00},   // green
      '{8'h00, 8'h00, 8'hFF},   // blue
      '{8'hFF, 8'hFF, 8'h00}    // yellow
   };

   localparam rgb_t BG_COLOUR = '{8'h10, 8'h10, 8'h10};

endpackage

// File: rtl/vga_axis_bounce.sv
// One axis of box motion: step, clamp at the walls, reverse and flag a bounce.
// Purely combinational; the parent holds the position/direction registers.
module vga_axis_bounce
   import vga_gfx_pkg::*;
#(
   parameter int SPEED = SPEED_DEF
) (
   input  logic [POS_W-1:0] pos,
   input  logic             dir,       // 1 = increasing, 0 = decreasing
   input  logic             step,
   input  logic [POS_W-1:0] max_pos,
   output logic [POS_W-1:0] next_pos,
   output logic             next_dir,
   output logic             bounce
);

   logic signed [POS_W-1:0] moved;

   // Signed step so an underflow is seen as negative before clamping to zero
   always_comb begin
      moved    = dir ? ($signed(pos) + $signed(POS_W'(SPEED)))
                     : ($signed(pos) - $signed(POS_W'(SPEED)));
      next_pos = pos;
      next_dir = dir;
      bounce   = 1'b0;
      if (step) begin
         if (moved > $signed(max_pos)) begin
            next_pos = max_pos;
            next_dir = ~dir;
            bounce   = 1'b1;
         end else if (moved[POS_W-1]) begin
            next_pos = '0;
            next_dir = ~dir;
            bounce   = 1'b1;
         end else begin
            next_pos = $unsigned(moved);
         end
      end
   end

endmodule

// File: rtl/vga_bounce_box_gen.sv
// Pixel source for the VGA driver: grey background with a square box that
// moves once per frame during vertical blank and changes colour on each bounce.
module vga_bounce_box_gen
   import vga_gfx_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int H_OFFSET = H_OFFSET_DEF,
   parameter int V_OFFSET = V_OFFSET_DEF,
   parameter int BOX_SIZE = BOX_SIZE_DEF,
   parameter int SPEED    = SPEED_DEF
) (
   input  logic        clk_pix,
   input  logic        rst_n,
   input  logic [10:0] H_Cont,
   input  logic [10:0] V_Cont,
   input  logic        move_en,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic        frame_tick,
   output logic [7:0]  bounce_cnt
);

   localparam logic [POS_W-1:0] MAX_X = POS_W'(H_ACTIVE - BOX_SIZE);
   localparam logic [POS_W-1:0] MAX_Y = POS_W'(V_ACTIVE - BOX_SIZE);

   upd_state_t       state, state_nxt;
   logic [POS_W-1:0] box_x, box_y, nx_x, nx_y;
   logic             dir_x, dir_y, nd_x, nd_y;
   logic             bnc_x, bnc_y, bounce_flag;
   logic [1:0]       idx;
   logic             trig;

   logic [POS_W-1:0] hc, vc, px, py;
   logic             vis, in_box;
   rgb_t             pix_d, pix_q;

   // ---------------- draw path ----------------
   assign hc = {1'b0, H_Cont};
   assign vc = {1'b0, V_Cont};
   assign px = hc - POS_W'(H_OFFSET);
   assign py = vc - POS_W'(V_OFFSET);

   assign vis = (hc >= POS_W'(H_OFFSET)) && (hc < POS_W'(H_OFFSET + H_ACTIVE)) &&
                (vc >= POS_W'(V_OFFSET)) && (vc < POS_W'(V_OFFSET + V_ACTIVE));
   assign in_box = (px >= box_x) && (px < box_x + POS_W'(BOX_SIZE)) &&
                   (py >= box_y) && (py < box_y + POS_W'(BOX_SIZE));

   // Select box colour, background, or black outside the active area
   always_comb begin
      pix_d = '0;
      if (vis) pix_d = in_box ? PALETTE[idx] : BG_COLOUR;
   end

   // Register the pixel so outputs lag the counter sample by exactly one clock
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) pix_q <= '0;
      else        pix_q <= pix_d;
   end

   assign pix_r = pix_q.r;
   assign pix_g = pix_q.g;
   assign pix_b = pix_q.b;

   // ---------------- frame update FSM ----------------
   // First blanking line start: position may change without tearing
   assign trig = (H_Cont == 11'd0) && (V_Cont == 11'(V_OFFSET + V_ACTIVE));

   // State register
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: a frozen box skips the axis steps but still reports the frame
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (trig) state_nxt = move_en ? UPD_X : DONE;
         UPD_X:   state_nxt = UPD_Y;
         UPD_Y:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: frame_tick marks the completed update
   always_comb begin
      frame_tick = (state == DONE);
   end

   vga_axis_bounce #(.SPEED(SPEED)) u_axis_x (
      .pos(box_x), .dir(dir_x), .step(state == UPD_X), .max_pos(MAX_X),
      .next_pos(nx_x), .next_dir(nd_x), .bounce(bnc_x)
   );

   vga_axis_bounce #(.SPEED(SPEED)) u_axis_y (
      .pos(box_y), .dir(dir_y), .step(state == UPD_Y), .max_pos(MAX_Y),
      .next_pos(nx_y), .next_dir(nd_y), .bounce(bnc_y)
   );

   // Position/direction follow the axis cores; bounces collapse into one colour step per frame
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         box_x       <= '0;
         box_y       <= '0;
         dir_x       <= 1'b1;
         dir_y       <= 1'b1;
         idx         <= '0;
         bounce_flag <= 1'b0;
         bounce_cnt  <= '0;
      end else begin
         box_x <= nx_x;
         dir_x <= nd_x;
         box_y <= nx_y;
         dir_y <= nd_y;
         if (bnc_x || bnc_y) begin
            bounce_flag <= 1'b1;
         end else if ((state == DONE) && bounce_flag) begin
            idx         <= idx + 2'd1;
            bounce_cnt  <= bounce_cnt + 8'd1;
            bounce_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_bounce_box_gen.sv
// Bench for vga_bounce_box_gen: directed frames plus randomized raster probes
// checked against a plain-arithmetic model of box position, direction and colour.
module tb_vga_bounce_box_gen;

   localparam int HO = 144, VO = 35, HA = 640, VA = 480, BS = 32, SP = 2;
   localparam int MAXX = HA - BS, MAXY = VA - BS;
   localparam logic [23:0] RED = 24'hFF0000, BG = 24'h101010;

   logic        clk_pix = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] H_Cont = '0, V_Cont = '0;
   logic        move_en = 1'b0;
   logic [7:0]  pix_r, pix_g, pix_b, bounce_cnt;
   logic        frame_tick;
   logic [23:0] pix;

   int n_assert = 0, n_fail = 0;

   // model state
   int mx, my, mdx, mdy, midx, mcnt;

   assign pix = {pix_r, pix_g, pix_b};

   always #5 clk_pix = ~clk_pix;

   vga_bounce_box_gen dut (
      .clk_pix(clk_pix), .rst_n(rst_n), .H_Cont(H_Cont), .V_Cont(V_Cont),
      .move_en(move_en), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .frame_tick(frame_tick), .bounce_cnt(bounce_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] pal(input int i);
      case (i)
         0:       return 24'hFF0000;
         1:       return 24'h00FF00;
         2:       return 24'h0000FF;
         default: return 24'hFFFF00;
      endcase
   endfunction

   function automatic logic [23:0] exp_pix(input int h, input int v);
      int x, y;
      x = h - HO;
      y = v - VO;
      if (x < 0 || x >= HA || y < 0 || y >= VA) return 24'h0;
      if (x >= mx && x < mx + BS && y >= my && y < my + BS) return pal(midx);
      return BG;
   endfunction

   task automatic model_reset();
      mx = 0; my = 0; mdx = 1; mdy = 1; midx = 0; mcnt = 0;
   endtask

   task automatic axis(inout int p, inout int d, input int lim, output bit b);
      int n;
      n = p + d * SP;
      b = 1'b0;
      if (n > lim)      begin n = lim; d = -d; b = 1'b1; end
      else if (n < 0)   begin n = 0;   d = -d; b = 1'b1; end
      p = n;
   endtask

   function automatic bit will_bounce(input int p, input int d, input int lim);
      return (p + d * SP > lim) || (p + d * SP < 0);
   endfunction

   // inputs change 1 time unit after the rising edge; outputs sampled there too
   task automatic probe(input string tag, input int h, input int v);
      H_Cont = 11'(h);
      V_Cont = 11'(v);
      @(posedge clk_pix); #1;
      chk(tag, 32'(pix), 32'(exp_pix(h, v)));
   endtask

   task automatic probe_xy(input string tag, input int x, input int y);
      probe(tag, x + HO, y + VO);
   endtask

   task automatic probe_box();
      int rx, ry;
      probe_xy("box_top_left", mx, my);
      probe_xy("box_bottom_right", mx + BS - 1, my + BS - 1);
      if (mx > 0)       probe_xy("left_of_box", mx - 1, my);
      if (mx + BS < HA) probe_xy("right_of_box", mx + BS, my);
      if (my > 0)       probe_xy("above_box", mx, my - 1);
      if (my + BS < VA) probe_xy("below_box", mx, my + BS);
      rx = $urandom_range(HA - 1);
      ry = $urandom_range(VA - 1);
      probe_xy("random_visible", rx, ry);
   endtask

   // One blank-line trigger followed by idle counters until the FSM is back in IDLE
   task automatic do_frame(input bit en);
      int ticks;
      bit bx, by;
      ticks = 0;
      move_en = en;
      H_Cont = 11'd0;
      V_Cont = 11'(VO + VA);
      @(posedge clk_pix); #1;
      ticks += int'(frame_tick);
      V_Cont = 11'd0;
      repeat (3) begin
         @(posedge clk_pix); #1;
         ticks += int'(frame_tick);
      end
      if (en) begin
         axis(mx, mdx, MAXX, bx);
         axis(my, mdy, MAXY, by);
         if (bx || by) begin
            midx = (midx + 1) % 4;
            mcnt = (mcnt + 1) % 256;
         end
      end
      chk("frame_tick_count", 32'(ticks), 32'd1);
      chk("bounce_cnt", 32'(bounce_cnt), 32'(mcnt));
   endtask

   initial begin
      int moved, iter, h, v, ticks, c0, gaps;
      bit corner_seen;

      // ---- reset values ----
      model_reset();
      repeat (3) @(posedge clk_pix);
      #1;
      chk("reset_pix", 32'(pix), 32'd0);
      chk("reset_frame_tick", 32'(frame_tick), 32'd0);
      chk("reset_bounce_cnt", 32'(bounce_cnt), 32'd0);
      rst_n = 1'b1;

      // ---- first frame drawing and latency ----
      probe_xy("bg_32_0", 32, 0);
      chk("bg_32_0_const", 32'(pix), 32'(BG));
      H_Cont = 11'(HO); V_Cont = 11'(VO);
      #1;
      chk("latency_hold", 32'(pix), 32'(BG));
      @(posedge clk_pix); #1;
      chk("pix_0_0_red", 32'(pix), 32'(RED));
      probe("left_blank", HO - 1, VO);
      chk("left_blank_const", 32'(pix), 32'd0);
      probe_xy("pix_31_31", 31, 31);
      probe_xy("pix_0_32", 0, 32);
      probe("bottom_blank", HO, VO + VA);

      // ---- one moving frame ----
      do_frame(1'b1);
      probe_xy("pix_1_1", 1, 1);
      chk("pix_1_1_bg", 32'(pix), 32'(BG));
      probe_xy("pix_2_2", 2, 2);
      chk("pix_2_2_red", 32'(pix), 32'(RED));
      probe_xy("pix_33_33", 33, 33);
      probe_xy("pix_34_2", 34, 2);

      // ---- frozen frames ----
      repeat (3) do_frame(1'b0);
      probe_xy("frozen_2_2", 2, 2);
      chk("frozen_2_2_red", 32'(pix), 32'(RED));
      probe_xy("frozen_1_1", 1, 1);
      probe_xy("frozen_34_34", 34, 34);

      // ---- randomized frames through the first x and y wall hits ----
      moved = 0;
      iter = 0;
      while (moved < 310 && iter < 2000) begin
         move_en = ($urandom_range(9) != 0);
         do_frame(move_en);
         if (move_en) moved++;
         iter++;
         probe_box();
         gaps = $urandom_range(3);
         repeat (gaps) begin
            h = $urandom_range(799);
            v = $urandom_range(524);
            if (h == 0 && v == VO + VA) h = 1;
            probe("random_raster", h, v);
         end
      end

      // ---- run on to a simultaneous x/y wall hit ----
      corner_seen = 1'b0;
      for (int i = 0; i < 20000 && !corner_seen; i++) begin
         if (will_bounce(mx, mdx, MAXX) && will_bounce(my, mdy, MAXY)) begin
            c0 = mcnt;
            do_frame(1'b1);
            chk("corner_single_count", 32'(bounce_cnt), 32'((c0 + 1) % 256));
            probe_box();
            do_frame(1'b1);
            probe_box();
            corner_seen = 1'b1;
         end else begin
            do_frame(1'b1);
            if (i % 1000 == 0) probe_box();
         end
      end
      chk("corner_reached", 32'(corner_seen), 32'd1);

      // ---- reset asserted while in UPD_X ----
      move_en = 1'b1;
      H_Cont = 11'd0;
      V_Cont = 11'(VO + VA);
      @(posedge clk_pix); #1;
      H_Cont = 11'(HO + mx);
      V_Cont = 11'(VO + my);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_pix", 32'(pix), 32'd0);
      chk("midreset_tick", 32'(frame_tick), 32'd0);
      chk("midreset_bounce_cnt", 32'(bounce_cnt), 32'd0);
      @(posedge clk_pix); #1;
      chk("midreset_pix_held", 32'(pix), 32'd0);
      rst_n = 1'b1;
      model_reset();
      ticks = 0;
      probe_xy("after_reset_0_0", 0, 0);
      ticks += int'(frame_tick);
      chk("after_reset_0_0_red", 32'(pix), 32'(RED));
      probe_xy("after_reset_31_31", 31, 31);
      ticks += int'(frame_tick);
      probe_xy("after_reset_32_32", 32, 32);
      ticks += int'(frame_tick);
      chk("after_reset_no_tick", 32'(ticks), 32'd0);
      do_frame(1'b1);
      probe_box();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
